mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Execute-stage multiply/divide unit controller for the pipelined MIPS core. It sits beside the ALU in E.
- Accepts mult/multu/div/divu/mthi/mtlo from E and models the multi-cycle latency with a busy counter.
- Owns the HI/LO registers and returns HI/LO for mfhi/mflo.
- Generates the D-stage stall request so that no MDU instruction enters E while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- E_MDU_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- E_MDU_A  input  32  forwarded rs value.
- E_MDU_B  input  32  forwarded rt value.
- D_MDU_use  input  1  instruction in D is any MDU op (1-8).
- E_MDU_start  output  1  combinational; 1 when E_MDU_op is 1-4.
- E_MDU_busy  output  1  registered; 1 while an operation is in flight.
- E_MDU_out  output  32  combinational; HI for mfhi, LO for mflo, else 0.
- D_MDU_stall  output  1  combinational; D_MDU_use & (E_MDU_start | E_MDU_busy).
- E_HI  output  32  current HI register.
- E_LO  output  32  current LO register.

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0: HI=0, LO=0, cnt=0, E_MDU_busy=0, pending result regs=0.
  - An operation in flight at reset is discarded and HI/LO are not written.
- Start in cycle S (E_MDU_start=1, E_MDU_busy=0):
  - At edge S, compute the result into pending regs pHI/pLO.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
- E_MDU_busy = (cnt != 0).
- Each edge with cnt != 0 decrements cnt. On the edge where cnt==1, write HI<=pHI and LO<=pLO.
- busy is high for cycles S+1 .. S+N; the new HI/LO are visible from cycle S+N+1.
- A start while busy=1 is ignored; D_MDU_stall prevents this legally. A bench assertion flags it.
- mult: {HI,LO} = signed A*B, 64-bit. multu: unsigned 64-bit product.
- div: LO = signed quotient truncated toward zero; HI = remainder, sign of dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0): the op still occupies DIV_CYCLES, but HI/LO are left unchanged at completion.
- mthi/mtlo: write HI (or LO) <= E_MDU_A at the edge of the issue cycle.
  - Only valid when busy=0, which the stall guarantees.
  - If one coincides with the final busy edge, the pending result wins. This cannot occur legally.
- mfhi/mflo: E_MDU_out reflects HI/LO combinationally. No internal bypass of the same-edge mthi/mtlo write, because the pipeline order makes it unnecessary.
- Stall:
  - D_MDU_stall is 1 during cycle S (start in E) and all busy cycles.
  - It falls in cycle S+N+1. Non-MDU instructions in D are never stalled by this block.
- Back-to-back: a new start is accepted in cycle S+N+1.

Test Plan:
- Reset: assert rst_n=0 mid-div (cnt=4), release -> busy=0, cnt=0, HI=LO=0; no later write occurs.
- mult, A=0xFFFFFFFE (-2), B=3 at cycle S -> busy=1 for S+1..S+5; cycle S+6 shows HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- div, A=-7, B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 7/0 following mtlo(0x1234) and mthi(0x5678) -> after 10 cycles HI=0x5678, LO=0x1234 unchanged.
- Stall: mult in E with D_MDU_use=1 -> D_MDU_stall=1 for 6 cycles (S..S+5).
  - With D_MDU_use=0 -> stall=0 throughout.
  - mflo in cycle S+6 -> E_MDU_out equals the new LO.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// E-stage MDU handshake bundle: operation/operands from the pipeline, status and HI/LO back.
// Signal names follow the core's existing E_/D_ naming so the pipeline wiring stays readable.
interface mdu_ctrl_if;
    logic [3:0]  E_MDU_op;
    logic [31:0] E_MDU_A;
    logic [31:0] E_MDU_B;
    logic        D_MDU_use;
    logic        E_MDU_start;
    logic        E_MDU_busy;
    logic [31:0] E_MDU_out;
    logic        D_MDU_stall;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    modport master (
        output E_MDU_op, E_MDU_A, E_MDU_B, D_MDU_use,
        input  E_MDU_start, E_MDU_busy, E_MDU_out, D_MDU_stall, E_HI, E_LO
    );

    modport slave (
        input  E_MDU_op, E_MDU_A, E_MDU_B, D_MDU_use,
        output E_MDU_start, E_MDU_busy, E_MDU_out, D_MDU_stall, E_HI, E_LO
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: owns HI/LO, models op latency with a
// down-counter and raises the D-stage stall while an MDU op occupies the unit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no op in flight, a start is accepted and its result latched
// ST_BUSY | counting down; pending HI/LO committed on the cnt==1 edge
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_ctrl_if.slave  mdu
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      phi_q, phi_d, plo_q, plo_d;
    logic             pwe_q, pwe_d;

    logic [3:0]  op;
    logic [31:0] a, b;
    logic        start, b_zero;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, quo_mag, rem_mag;
    logic [31:0] sdiv_q, sdiv_r, udiv_q, udiv_r;

    assign op = mdu.E_MDU_op;
    assign a  = mdu.E_MDU_A;
    assign b  = mdu.E_MDU_B;

    assign start  = (op >= OP_MULT) && (op <= OP_DIVU);
    assign b_zero = (b == 32'd0);

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    assign a_mag   = a[31] ? (~a + 32'd1) : a;
    assign b_mag   = b[31] ? (~b + 32'd1) : b;
    assign quo_mag = b_zero ? 32'd0 : (a_mag / b_mag);
    assign rem_mag = b_zero ? 32'd0 : (a_mag % b_mag);
    assign sdiv_q  = (a[31] ^ b[31]) ? (~quo_mag + 32'd1) : quo_mag;
    assign sdiv_r  = a[31] ? (~rem_mag + 32'd1) : rem_mag;
    assign udiv_q  = b_zero ? 32'd0 : (a / b);
    assign udiv_r  = b_zero ? 32'd0 : (a % b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwe_q   <= pwe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwe_d   = pwe_q;

        if (op == OP_MTHI) hi_d = a;
        if (op == OP_MTLO) lo_d = a;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    pwe_d   = 1'b1;
                    case (op)
                        OP_MULT: begin
                            cnt_d = MULT_LOAD;
                            phi_d = prod_s[63:32];
                            plo_d = prod_s[31:0];
                        end
                        OP_MULTU: begin
                            cnt_d = MULT_LOAD;
                            phi_d = prod_u[63:32];
                            plo_d = prod_u[31:0];
                        end
                        OP_DIV: begin
                            cnt_d = DIV_LOAD;
                            phi_d = sdiv_r;
                            plo_d = sdiv_q;
                            pwe_d = !b_zero;
                        end
                        default: begin
                            cnt_d = DIV_LOAD;
                            phi_d = udiv_r;
                            plo_d = udiv_q;
                            pwe_d = !b_zero;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                // The completing result overrides a coincident mthi/mtlo.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    if (pwe_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mdu.E_MDU_start = start;
    assign mdu.E_MDU_busy  = (cnt_q != '0);
    assign mdu.D_MDU_stall = mdu.D_MDU_use & (start | (cnt_q != '0));
    assign mdu.E_MDU_out   = (op == OP_MFHI) ? hi_q :
                             (op == OP_MFLO) ? lo_q : 32'd0;
    assign mdu.E_HI        = hi_q;
    assign mdu.E_LO        = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random traffic against a
// cycle-indexed reference model using 64-bit arithmetic.
module tb_mdu_ctrl;
    localparam int NMUL = 5;
    localparam int NDIV = 10;

    logic clk;
    logic rst_n;
    mdu_ctrl_if mif ();

    mdu_ctrl #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference state: architectural HI/LO plus the window of the op in flight
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    bit          m_pwe = 1'b0;
    int          cyc = 0, m_s = -1, m_end = -1;
    logic        last_busy, last_stall;

    always @(negedge clk)
        if (rst_n && mif.E_MDU_start && mif.E_MDU_busy)
            $error("MDU start issued while unit busy");

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit model_busy();
        return (cyc > m_s) && (cyc <= m_end);
    endfunction

    task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input bit accept);
        longint sa, sb, q, r, p;
        longint unsigned ua, ub, pu;
        if (op == 4'd5) m_hi = a;
        if (op == 4'd6) m_lo = a;
        if (cyc == m_end && m_pwe) begin
            m_hi = m_phi;
            m_lo = m_plo;
        end
        if (accept) begin
            sa = $signed(a);
            sb = $signed(b);
            ua = a;
            ub = b;
            m_s   = cyc;
            m_pwe = 1'b1;
            case (op)
                4'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; m_end = cyc + NMUL; end
                4'd2: begin pu = ua * ub; m_phi = pu[63:32]; m_plo = pu[31:0]; m_end = cyc + NMUL; end
                4'd3: begin
                    m_end = cyc + NDIV;
                    if (b == 0) m_pwe = 1'b0;
                    else begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
                end
                default: begin
                    m_end = cyc + NDIV;
                    if (b == 0) m_pwe = 1'b0;
                    else begin m_plo = a / b; m_phi = a % b; end
                end
            endcase
        end
        cyc++;
    endtask

    // One pipeline cycle: drive E/D inputs, check every output, then take the edge.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d);
        logic e_start, e_busy, e_stall;
        logic [31:0] e_out;
        mif.E_MDU_op  = op;
        mif.E_MDU_A   = a;
        mif.E_MDU_B   = b;
        mif.D_MDU_use = use_d;
        #2;
        e_start = (op >= 4'd1) && (op <= 4'd4);
        e_busy  = model_busy();
        e_stall = use_d && (e_start || e_busy);
        e_out   = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        check("start", 32'(mif.E_MDU_start), 32'(e_start));
        check("busy",  32'(mif.E_MDU_busy),  32'(e_busy));
        check("stall", 32'(mif.D_MDU_stall), 32'(e_stall));
        check("out",   mif.E_MDU_out, e_out);
        check("hi",    mif.E_HI, m_hi);
        check("lo",    mif.E_LO, m_lo);
        last_busy  = mif.E_MDU_busy;
        last_stall = mif.D_MDU_stall;
        @(posedge clk);
        model_edge(op, a, b, e_start && !e_busy);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, input int n, output int bc, output int sc);
        step(op, a, b, use_d);
        bc = int'(last_busy);
        sc = int'(last_stall);
        repeat (n) begin
            step(4'd0, 32'd0, 32'd0, use_d);
            bc += int'(last_busy);
            sc += int'(last_stall);
        end
    endtask

    int bc, sc;
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;

    initial begin
        rst_n = 1'b0;
        mif.E_MDU_op = '0; mif.E_MDU_A = '0; mif.E_MDU_B = '0; mif.D_MDU_use = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_busy", 32'(mif.E_MDU_busy), 32'd0);
        check("rst_hi", mif.E_HI, 32'd0);
        check("rst_lo", mif.E_LO, 32'd0);
        step(4'd0, 32'd0, 32'd0, 1'b1);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, NMUL, bc, sc);
        check("mult_busy_cycles", 32'(bc), 32'd5);
        check("mult_stall_cycles", 32'(sc), 32'd6);
        step(4'd8, 32'd0, 32'd0, 1'b1);
        check("mult_stall_release", 32'(last_stall), 32'd0);
        check("mult_hi", mif.E_HI, 32'hFFFF_FFFF);
        check("mflo_out", mif.E_MDU_out, 32'hFFFF_FFFA);

        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, NMUL, bc, sc);
        check("multu_busy_cycles", 32'(bc), 32'd5);
        check("multu_nouse_stall", 32'(sc), 32'd0);
        step(4'd0, 32'd0, 32'd0, 1'b0);
        check("multu_hi", mif.E_HI, 32'h0000_0002);
        check("multu_lo", mif.E_LO, 32'hFFFF_FFFA);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, NDIV, bc, sc);
        check("div_busy_cycles", 32'(bc), 32'd10);
        step(4'd7, 32'd0, 32'd0, 1'b1);
        check("div_lo", mif.E_LO, 32'hFFFF_FFFD);
        check("mfhi_out", mif.E_MDU_out, 32'hFFFF_FFFF);

        step(4'd6, 32'h0000_1234, 32'd0, 1'b1);
        step(4'd5, 32'h0000_5678, 32'd0, 1'b1);
        run_op(4'd4, 32'd7, 32'd0, 1'b1, NDIV, bc, sc);
        check("divz_busy_cycles", 32'(bc), 32'd10);
        step(4'd0, 32'd0, 32'd0, 1'b0);
        check("divz_hi", mif.E_HI, 32'h0000_5678);
        check("divz_lo", mif.E_LO, 32'h0000_1234);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, NDIV, bc, sc);
        step(4'd0, 32'd0, 32'd0, 1'b0);
        check("ovf_lo", mif.E_LO, 32'h8000_0000);
        check("ovf_hi", mif.E_HI, 32'h0000_0000);

        // reset with a div in flight at cnt=4; its result must never land
        run_op(4'd3, 32'd100, 32'd7, 1'b0, 6, bc, sc);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(mif.E_MDU_busy), 32'd0);
        check("rst_mid_hi", mif.E_HI, 32'd0);
        check("rst_mid_lo", mif.E_LO, 32'd0);
        #1 rst_n = 1'b1;
        m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pwe = 1'b0; m_s = -1; m_end = -1;
        run_op(4'd0, 32'd0, 32'd0, 1'b1, 11, bc, sc);
        check("rst_no_write_busy", 32'(bc), 32'd0);
        check("rst_no_write_hi", mif.E_HI, 32'd0);
        check("rst_no_write_lo", mif.E_LO, 32'd0);

        repeat (600) begin
            r_op = 4'($urandom_range(0, 15));
            if (model_busy() && r_op >= 4'd1 && r_op <= 4'd8) r_op = 4'd0;
            case ($urandom_range(0, 7))
                0: r_a = 32'h8000_0000;
                1: r_a = 32'($urandom_range(0, 20));
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: r_b = 32'hFFFF_FFFF;
                2: r_b = 32'($urandom_range(1, 9));
                default: r_b = $urandom;
            endcase
            step(r_op, r_a, r_b, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
